// File: rtl/twiddle_cmult_stage_pkg.sv
// Shared FFT constants and twiddle generation for the radix-2 twiddle stage.
// Twiddles are built at elaboration with integer fixed-point sin/cos series.
package twiddle_cmult_stage_pkg;

  localparam int     NUM_LANES = 2;
  localparam int     STAGES    = 3;
  localparam int     FX        = 28;
  localparam longint ONE_FX    = longint'(1) <<< FX;
  localparam longint PI_FX     = 64'sd843314857;

  function automatic longint fx_angle(input int num, input int den);
    return (2 * PI_FX * longint'(num)) / longint'(den);
  endfunction

  // Taylor series; angles stay below pi so 15 terms are far below 1 LSB.
  function automatic longint fx_sincos(input longint x, input bit want_sin);
    longint term, sum, den;
    term = want_sin ? x : ONE_FX;
    sum  = term;
    for (int n = 1; n < 16; n++) begin
      den  = want_sin ? longint'(2*n*(2*n+1)) : longint'((2*n-1)*2*n);
      term = (term * x) >>> FX;
      term = (term * x) >>> FX;
      term = -term / den;
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int fx_round(input longint v, input int sh);
    longint s, half;
    s    = v <<< sh;
    half = ONE_FX >>> 1;
    return (s >= 0) ? int'((s + half) >>> FX) : -int'((half - s) >>> FX);
  endfunction

  function automatic int twiddle_re(input int k, input int lane, input int n, input int nbc);
    return fx_round(fx_sincos(fx_angle(2*k + lane, 4*n), 1'b0), nbc - 2);
  endfunction

  function automatic int twiddle_im(input int k, input int lane, input int n, input int nbc);
    return -fx_round(fx_sincos(fx_angle(2*k + lane, 4*n), 1'b1), nbc - 2);
  endfunction

endpackage

// File: rtl/twiddle_cmult_stage_cmult.sv
// One lane: 3-stage complex multiply of the down sample by its twiddle,
// with the up sample delayed and scaled to the same fixed-point weight.
module cmult_pipe #(
  parameter int NBITS      = 10,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NBITS-1:0]      in_up,
  input  logic [2*NBITS-1:0]      in_dn,
  input  logic [2*NBITScoeff-1:0] coef,
  output logic [2*NBITS_out-1:0]  out_up,
  output logic [2*NBITS_out-1:0]  out_dn
);
  localparam int PW = NBITS + NBITScoeff;
  localparam int SH = NBITScoeff - 2;

  logic signed [NBITS-1:0]      ur_q, ui_q, ar_q, ai_q, ur_d, ui_d, ar_d, ai_d;
  logic signed [NBITScoeff-1:0] wr_q, wi_q, wr_d, wi_d;
  logic signed [NBITS-1:0]      ur2_q, ui2_q, ur2_d, ui2_d;
  logic signed [PW-1:0]         p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0]         p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [NBITS_out-1:0]  ur3_q, ui3_q, re_q, im_q, ur3_d, ui3_d, re_d, im_d;

  always_comb begin
    {ur_d, ui_d} = in_up;
    {ar_d, ai_d} = in_dn;
    {wr_d, wi_d} = coef;
    ur2_d  = ur_q;
    ui2_d  = ui_q;
    p_rr_d = PW'(ar_q) * PW'(wr_q);
    p_ii_d = PW'(ai_q) * PW'(wi_q);
    p_ri_d = PW'(ar_q) * PW'(wi_q);
    p_ir_d = PW'(ai_q) * PW'(wr_q);
    // Products are exact in PW bits, so extending before the add cannot wrap.
    re_d   = NBITS_out'(p_rr_q) - NBITS_out'(p_ii_q);
    im_d   = NBITS_out'(p_ri_q) + NBITS_out'(p_ir_q);
    ur3_d  = NBITS_out'(ur2_q) <<< SH;
    ui3_d  = NBITS_out'(ui2_q) <<< SH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ur_q   <= '0; ui_q   <= '0; ar_q   <= '0; ai_q   <= '0;
      wr_q   <= '0; wi_q   <= '0;
      ur2_q  <= '0; ui2_q  <= '0;
      p_rr_q <= '0; p_ii_q <= '0; p_ri_q <= '0; p_ir_q <= '0;
      ur3_q  <= '0; ui3_q  <= '0; re_q   <= '0; im_q   <= '0;
    end else begin
      ur_q   <= ur_d;   ui_q   <= ui_d;   ar_q   <= ar_d;   ai_q   <= ai_d;
      wr_q   <= wr_d;   wi_q   <= wi_d;
      ur2_q  <= ur2_d;  ui2_q  <= ui2_d;
      p_rr_q <= p_rr_d; p_ii_q <= p_ii_d; p_ri_q <= p_ri_d; p_ir_q <= p_ir_d;
      ur3_q  <= ur3_d;  ui3_q  <= ui3_d;  re_q   <= re_d;   im_q   <= im_d;
    end
  end

  assign out_up = {ur3_q, ui3_q};
  assign out_dn = {re_q, im_q};

endmodule

// File: rtl/twiddle_cmult_stage.sv
// Twiddle multiply stage after the delay commutator: coefficient index,
// per-lane constant ROMs and two cmult_pipe lanes, plus the valid chain.
module twiddle_cmult_stage
  import twiddle_cmult_stage_pkg::*;
#(
  parameter int NBITS      = 10,
  parameter int NBITScoeff = NBITS + 1,
  parameter int NBITS_out  = 21,
  parameter int N          = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2*NBITS-1:0]     fftIn0_up,
  input  logic [2*NBITS-1:0]     fftIn0_down,
  input  logic [2*NBITS-1:0]     fftIn1_up,
  input  logic [2*NBITS-1:0]     fftIn1_down,
  output logic [2*NBITS_out-1:0] fftOut0_up,
  output logic [2*NBITS_out-1:0] fftOut0_down,
  output logic [2*NBITS_out-1:0] fftOut1_up,
  output logic [2*NBITS_out-1:0] fftOut1_down,
  output logic                   out_valid
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  logic [KW-1:0]      k_q, k_d;
  logic [STAGES:1]    vld_pipe_q, vld_pipe_d;

  logic [NUM_LANES-1:0][N-1:0][2*NBITScoeff-1:0] coef_tab;
  logic [NUM_LANES-1:0][2*NBITS-1:0]             in_up, in_dn;
  logic [NUM_LANES-1:0][2*NBITS_out-1:0]         out_up, out_dn;

  assign in_up = {fftIn1_up, fftIn0_up};
  assign in_dn = {fftIn1_down, fftIn0_down};

  // A dropped enable restarts the frame, so k never resumes mid-sequence.
  always_comb begin
    k_d        = en ? ((k_q == KW'(N - 1)) ? '0 : k_q + 1'b1) : '0;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], en};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q        <= '0;
      vld_pipe_q <= '0;
    end else begin
      k_q        <= k_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    for (genvar i = 0; i < N; i++) begin : g_tab
      localparam int WR = twiddle_re(i, l, N, NBITScoeff);
      localparam int WI = twiddle_im(i, l, N, NBITScoeff);
      assign coef_tab[l][i] = {NBITScoeff'(WR), NBITScoeff'(WI)};
    end

    cmult_pipe #(
      .NBITS      (NBITS),
      .NBITScoeff (NBITScoeff),
      .NBITS_out  (NBITS_out)
    ) u_cmult (
      .clk    (clk),
      .rst    (rst),
      .in_up  (in_up[l]),
      .in_dn  (in_dn[l]),
      .coef   (coef_tab[l][k_q]),
      .out_up (out_up[l]),
      .out_dn (out_dn[l])
    );
  end

  assign fftOut0_up   = out_up[0];
  assign fftOut0_down = out_dn[0];
  assign fftOut1_up   = out_up[1];
  assign fftOut1_down = out_dn[1];
  assign out_valid    = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_twiddle_cmult_stage.sv
// Randomised bench for twiddle_cmult_stage against a real-arithmetic model.
`timescale 1ns/1ps
module tb_twiddle_cmult_stage;
  localparam int  NB  = 10;
  localparam int  NBC = 11;
  localparam int  NBO = 21;
  localparam int  N   = 32;
  localparam int  W   = 2*NBO;
  localparam int  SCALE_I = 1 << (NBC - 2);
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [2*NB-1:0] i0u = '0, i0d = '0, i1u = '0, i1d = '0;
  logic [W-1:0]    o0u, o0d, o1u, o1d;
  logic            out_valid;
  wire  [4*W-1:0]  outs = {o0u, o0d, o1u, o1d};

  always #5 clk = ~clk;

  twiddle_cmult_stage #(.NBITS(NB), .NBITScoeff(NBC), .NBITS_out(NBO), .N(N)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fftIn0_up(i0u), .fftIn0_down(i0d), .fftIn1_up(i1u), .fftIn1_down(i1d),
    .fftOut0_up(o0u), .fftOut0_down(o0d), .fftOut1_up(o1u), .fftOut1_down(o1d),
    .out_valid(out_valid)
  );

  typedef struct { bit v; logic [4*W-1:0] o; } exp_t;
  exp_t pipe[$];
  exp_t cur;
  int   k_mdl;
  int   errs = 0, checks = 0;

  function automatic int rnd_away(input real x);
    return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
  endfunction

  function automatic logic [W-1:0] m_up(input logic [2*NB-1:0] a);
    logic [63:0] rv, iv;
    rv = longint'($signed(a[2*NB-1:NB])) * SCALE_I;
    iv = longint'($signed(a[NB-1:0])) * SCALE_I;
    return {rv[NBO-1:0], iv[NBO-1:0]};
  endfunction

  function automatic logic [W-1:0] m_dn(input logic [2*NB-1:0] a, input int lane, input int k);
    real th; longint ar, ai, wr, wi; logic [63:0] rv, iv;
    th = 2.0 * PI * real'(2*k + lane) / (4.0 * N);
    wr = rnd_away(real'(SCALE_I) * $cos(th));
    wi = rnd_away(-real'(SCALE_I) * $sin(th));
    ar = longint'($signed(a[2*NB-1:NB]));
    ai = longint'($signed(a[NB-1:0]));
    rv = ar*wr - ai*wi;
    iv = ar*wi + ai*wr;
    return {rv[NBO-1:0], iv[NBO-1:0]};
  endfunction

  function automatic logic [2*NB-1:0] rdat();
    return (2*NB)'($urandom);
  endfunction

  task automatic model_reset();
    pipe.delete();
    cur.v = 1'b0;
    cur.o = '0;
    pipe.push_back(cur);
    pipe.push_back(cur);
    k_mdl = 0;
  endtask

  // Apply one sample, record its expected result, advance one clock.
  task automatic drive(input bit e, input logic [2*NB-1:0] a, b, c, d);
    exp_t x;
    en = e; i0u = a; i0d = b; i1u = c; i1d = d;
    x.v = e;
    x.o = {m_up(a), m_dn(b, 0, k_mdl), m_up(c), m_dn(d, 1, k_mdl)};
    pipe.push_back(x);
    k_mdl = e ? (k_mdl + 1) % N : 0;
    @(posedge clk); #1;
    cur = pipe.pop_front();
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; i0u = rdat(); i0d = rdat(); i1u = rdat(); i1d = rdat();
      @(posedge clk); #1;
      checks++;
      if (outs !== '0 || out_valid !== 1'b0) begin
        errs++; $display("FAIL reset: out=%h valid=%b, want all 0", outs, out_valid);
      end
    end
    en = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_lane0_k0();
    drive(0, rdat(), rdat(), rdat(), rdat());
    drive(0, rdat(), rdat(), rdat(), rdat());
    drive(1, {10'sd3, -10'sd2}, {10'sd100, 10'sd0}, rdat(), rdat());
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL lane0_pre valid=%b want 0", out_valid); end
      drive(0, rdat(), rdat(), rdat(), rdat());
    end
    checks++;
    if (out_valid !== 1'b1 || o0d !== {21'sd51200, 21'sd0} || o0u !== {21'sd1536, -21'sd1024}) begin
      errs++; $display("FAIL lane0_k0: valid=%b down=%h up=%h", out_valid, o0d, o0u);
    end
    checks++;
    if (outs !== cur.o) begin errs++; $display("FAIL lane0_model: out=%h exp=%h", outs, cur.o); end
  endtask

  task automatic test_lane1_k0();
    drive(0, rdat(), rdat(), rdat(), rdat());
    drive(1, rdat(), rdat(), rdat(), {10'sd1, 10'sd0});
    drive(0, rdat(), rdat(), rdat(), rdat());
    drive(0, rdat(), rdat(), rdat(), rdat());
    checks++;
    if (out_valid !== 1'b1 || o1d !== {21'sd511, -21'sd25}) begin
      errs++; $display("FAIL lane1_k0: valid=%b down=%h want %h", out_valid, o1d, {21'sd511, -21'sd25});
    end
  endtask

  task automatic test_extreme();
    drive(0, rdat(), rdat(), rdat(), rdat());
    for (int i = 0; i < 16; i++) begin
      drive(1, rdat(), rdat(), rdat(), rdat());
      checks++;
      if (out_valid !== cur.v || (cur.v && outs !== cur.o)) begin
        errs++; $display("FAIL extreme_fill: valid=%b/%b out=%h exp=%h", out_valid, cur.v, outs, cur.o);
      end
    end
    drive(1, {10'h200, 10'h200}, {10'h200, 10'h200}, {10'h200, 10'h1ff}, {10'h1ff, 10'h200});
    drive(1, rdat(), rdat(), rdat(), rdat());
    drive(1, rdat(), rdat(), rdat(), rdat());
    checks++;
    if (o0d !== {-21'sd262144, 21'sd262144}) begin
      errs++; $display("FAIL extreme_k16: got %h want %h", o0d, {-21'sd262144, 21'sd262144});
    end
    checks++;
    if (out_valid !== 1'b1 || outs !== cur.o) begin
      errs++; $display("FAIL extreme_model: out=%h exp=%h", outs, cur.o);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] obs[$];
    logic [W-1:0] want;
    drive(0, rdat(), rdat(), rdat(), rdat());
    drive(0, rdat(), rdat(), rdat(), rdat());
    for (int i = 0; i < 42; i++) begin
      if (i < 40) drive(1, rdat(), {10'sd1, 10'sd0}, rdat(), rdat());
      else        drive(0, rdat(), rdat(), rdat(), rdat());
      if (cur.v) obs.push_back(o0d);
    end
    checks++;
    if (obs.size() != 40) begin
      errs++; $display("FAIL wrap_count: got %0d samples want 40", obs.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        want = m_dn({10'sd1, 10'sd0}, 0, j);
        checks++;
        if (obs[32+j] !== want || obs[j] !== want) begin
          errs++; $display("FAIL wrap_k%0d: cyc%0d=%h cyc%0d=%h want %h", j, j, obs[j], 32+j, obs[32+j], want);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    logic [14:0] vhist = '0;
    drive(0, rdat(), rdat(), rdat(), rdat());
    drive(0, rdat(), rdat(), rdat(), rdat());
    for (int j = 1; j <= 15; j++) begin
      if (j == 11 || j == 12) drive(0, rdat(), rdat(), rdat(), rdat());
      else if (j == 13)       drive(1, rdat(), {10'sd1, 10'sd0}, rdat(), rdat());
      else                    drive(1, rdat(), rdat(), rdat(), rdat());
      vhist = {vhist[13:0], out_valid};
      checks++;
      if (out_valid !== cur.v || (cur.v && outs !== cur.o)) begin
        errs++; $display("FAIL en_drop_model: j=%0d valid=%b/%b out=%h exp=%h", j, out_valid, cur.v, outs, cur.o);
      end
    end
    checks++;
    if (vhist !== 15'b001111111111001) begin
      errs++; $display("FAIL en_drop_valid: got %b want %b", vhist, 15'b001111111111001);
    end
    checks++;
    if (o0d !== {21'sd512, 21'sd0}) begin
      errs++; $display("FAIL en_drop_k0: got %h want %h", o0d, {21'sd512, 21'sd0});
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) drive(1, rdat(), rdat(), rdat(), rdat());
    #3 rst = 1'b0;
    #1;
    checks++;
    if (outs !== '0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL async_reset: out=%h valid=%b want 0", outs, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, rdat(), rdat(), rdat(), rdat());
      checks++;
      if (out_valid !== cur.v || (cur.v && outs !== cur.o)) begin
        errs++; $display("FAIL reset_resume: i=%0d valid=%b/%b out=%h exp=%h", i, out_valid, cur.v, outs, cur.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 9) != 0), rdat(), rdat(), rdat(), rdat());
      checks++;
      if (out_valid !== cur.v || (cur.v && outs !== cur.o)) begin
        errs++; $display("FAIL random: i=%0d valid=%b/%b out=%h exp=%h", i, out_valid, cur.v, outs, cur.o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lane0_k0();
    test_lane1_k0();
    test_extreme();
    test_wrap();
    test_en_drop();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/twiddle_cmult_stage.md
TWIDDLE_CMULT_STAGE -- requirements
Module: twiddle_cmult_stage

Interface
REQ-001 SHALL have parameter NBITS, default 10, the signed width of each input real/imag component.
REQ-002 SHALL have parameter NBITScoeff, default NBITS+1, the signed width of each twiddle component.
REQ-003 SHALL have parameter NBITS_out, default 21, the signed width of each output component; NBITS_out >= NBITS+NBITScoeff is required.
REQ-004 SHALL have parameter N, default 32, the number of twiddle coefficients per lane.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: stage enable from the upstream enable delay chain.
REQ-008 SHALL have ports fftIn0_up, fftIn0_down, fftIn1_up and fftIn1_down, input, NBITS*2 bits each: delay-commutator outputs packed {re, im}, re in the upper half.
REQ-009 SHALL have ports fftOut0_up, fftOut0_down, fftOut1_up and fftOut1_down, output, NBITS_out*2 bits each, packed {re, im}.
REQ-010 SHALL have port out_valid, output, 1 bit: high when the fftOut* ports carry a result.

Function
REQ-011 SHALL hold a coefficient index k of log2(N) bits.
- k increments by 1 on each clk edge where en=1.
- k wraps from N-1 to 0.
- k is forced to 0 on each edge where en=0.
REQ-012 SHALL use twiddle W_L(k) = round(2^(NBITScoeff-2) * exp(-j*2*pi*(2k+L)/(4N))) for lane L in {0,1}; rounding is half away from zero, so 1.0 = 512 at the defaults.
REQ-013 SHALL compute each down output as the exact complex product fftInL_down * W_L(k), using the k sampled with the input.
- re = ar*wr - ai*wi
- im = ar*wi + ai*wr
- result sign-extended to NBITS_out bits
REQ-014 SHALL produce each up output as fftInL_up, sign-extended and shifted left by NBITScoeff-2, so the up and down outputs share one scale.
REQ-015 SHALL be a three-register pipeline with a latency of exactly 3 cycles:
- stage 1: input and coefficient registers
- stage 2: the four partial products
- stage 3: add/subtract and the output register
- up path: delayed by the same 3 cycles
REQ-016 SHALL drive out_valid equal to en delayed by 3 cycles.
REQ-017 SHALL clock the pipeline every cycle regardless of en; the fftOut* values are don't-care while out_valid=0.
REQ-018 SHALL let samples already in flight drain normally when en falls mid-frame; on re-assert, k restarts at 0.
REQ-019 SHALL produce no overflow; the NBITS+NBITScoeff bits of the result are exact for all inputs.

Reset
REQ-020 SHALL, while rst=0, asynchronously clear k, all pipeline registers, all fftOut* ports (to 0) and out_valid (to 0).
REQ-021 SHALL, on reset release mid-frame, resume with k=0 and out_valid=0 until 3 edges after en is next sampled high.

Structure
REQ-022 SHALL take the coefficient tables for lanes 0 and 1 (N entries each, {wr, wi}, NBITScoeff-bit signed) from the shared fft package as constants, generated there.
REQ-023 SHALL have one sub-module, cmult_pipe, instanced once per lane: a 3-stage complex multiplier plus its matching up-path delay.

Verification
REQ-024 SHALL include a reset scenario: drive rst=0 with random inputs and en=1 -> all outputs 0, out_valid=0.
REQ-025 SHALL include a lane 0, k=0 scenario: en rises with fftIn0_down=(100,0) and fftIn0_up=(3,-2) -> 3 cycles later fftOut0_down=(51200,0), fftOut0_up=(1536,-1024), out_valid=1.
REQ-026 SHALL include a lane 1, k=0 scenario: fftIn1_down=(1,0) -> fftOut1_down=(511,-25).
REQ-027 SHALL include an extreme-value scenario: fftIn0_down=(-512,-512) at lane 0, k=16, where W=(0,-512) -> output (-262144, 262144), with no wrap.
REQ-028 SHALL include a wrap scenario: 40 consecutive enabled cycles -> the coefficient used at cycles 32..39 equals that used at cycles 0..7.
REQ-029 SHALL include an en-drop scenario: drop en for 2 cycles at k=10, then re-assert.
- out_valid falls for 2 cycles, 3 cycles after the drop.
- the first sample after re-assert uses k=0.
